// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes, iterative shifts and an optional
// iterative unsigned multiplier (compiled in when ALU_MUL_EN is defined).
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             sign_flag,
    output logic             overflow_flag,
    output logic             illegal
);

    localparam int unsigned CW = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd8;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] result_d;
    logic             zero_d, carry_d, sign_d, overflow_d, illegal_d;
    logic [3:0]       op, op_d;
    logic [WIDTH-1:0] sh, sh_d;
    logic [CW-1:0]    cnt, cnt_d;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod, prod_d;
    logic [WIDTH-1:0]   mcand, mcand_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
`endif

    logic             fin, carry_v, ovf_v, ill_v, sh_bit;
    logic [WIDTH-1:0] res_v, sh_n;
    logic [WIDTH:0]   sum_v;

    assign in_ready = (state == IDLE) && !rst;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            result        <= '0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            sign_flag     <= 1'b0;
            overflow_flag <= 1'b0;
            illegal       <= 1'b0;
            op            <= '0;
            sh            <= '0;
            cnt           <= '0;
`ifdef ALU_MUL_EN
            prod          <= '0;
            mcand         <= '0;
`endif
        end else begin
            state         <= state_d;
            out_valid     <= out_valid_d;
            result        <= result_d;
            zero_flag     <= zero_d;
            carry_flag    <= carry_d;
            sign_flag     <= sign_d;
            overflow_flag <= overflow_d;
            illegal       <= illegal_d;
            op            <= op_d;
            sh            <= sh_d;
            cnt           <= cnt_d;
`ifdef ALU_MUL_EN
            prod          <= prod_d;
            mcand         <= mcand_d;
`endif
        end
    end

    // Next-state, datapath step and result capture
    always_comb begin
        state_d    = state;
        result_d   = result;
        zero_d     = zero_flag;
        carry_d    = carry_flag;
        sign_d     = sign_flag;
        overflow_d = overflow_flag;
        illegal_d  = illegal;
        op_d       = op;
        sh_d       = sh;
        cnt_d      = cnt;
`ifdef ALU_MUL_EN
        prod_d     = prod;
        mcand_d    = mcand;
        mul_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        mul_next   = {mul_sum, prod[WIDTH-1:1]};
`endif
        fin     = 1'b0;
        res_v   = '0;
        carry_v = 1'b0;
        ovf_v   = 1'b0;
        ill_v   = 1'b0;
        sum_v   = '0;
        sh_n    = sh;
        sh_bit  = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_d = control;
                    case (control)
                        OP_ADD: begin
                            sum_v   = {1'b0, a} + {1'b0, b};
                            res_v   = sum_v[WIDTH-1:0];
                            carry_v = sum_v[WIDTH];
                            ovf_v   = (a[WIDTH-1] == b[WIDTH-1]) && (res_v[WIDTH-1] != a[WIDTH-1]);
                            fin     = 1'b1;
                        end
                        OP_SUB: begin
                            sum_v   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                            res_v   = sum_v[WIDTH-1:0];
                            carry_v = sum_v[WIDTH];
                            ovf_v   = (a[WIDTH-1] != b[WIDTH-1]) && (res_v[WIDTH-1] != a[WIDTH-1]);
                            fin     = 1'b1;
                        end
                        OP_AND: begin res_v = a & b; fin = 1'b1; end
                        OP_OR:  begin res_v = a | b; fin = 1'b1; end
                        OP_XOR: begin res_v = a ^ b; fin = 1'b1; end
                        OP_SLL, OP_SRL, OP_SRA: begin
                            // A zero shift amount completes immediately with the operand unchanged
                            if (b[SHW-1:0] == '0) begin
                                res_v = a;
                                fin   = 1'b1;
                            end else begin
                                sh_d    = a;
                                cnt_d   = CW'(b[SHW-1:0]);
                                state_d = BUSY;
                            end
                        end
`ifdef ALU_MUL_EN
                        OP_MUL: begin
                            prod_d  = {WIDTH'(0), b};
                            mcand_d = a;
                            cnt_d   = CW'(WIDTH);
                            state_d = BUSY;
                        end
`endif
                        default: begin
                            ill_v = 1'b1;
                            fin   = 1'b1;
                        end
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt - CW'(1);
`ifdef ALU_MUL_EN
                if (op == OP_MUL) begin
                    prod_d = mul_next;
                    if (cnt == CW'(1)) begin
                        res_v   = mul_next[WIDTH-1:0];
                        carry_v = |mul_next[2*WIDTH-1:WIDTH];
                        ovf_v   = carry_v;
                        fin     = 1'b1;
                    end
                end else begin
`else
                begin
`endif
                    case (op)
                        OP_SLL:  begin sh_n = {sh[WIDTH-2:0], 1'b0};        sh_bit = sh[WIDTH-1]; end
                        OP_SRA:  begin sh_n = {sh[WIDTH-1], sh[WIDTH-1:1]}; sh_bit = sh[0]; end
                        default: begin sh_n = {1'b0, sh[WIDTH-1:1]};        sh_bit = sh[0]; end
                    endcase
                    sh_d = sh_n;
                    if (cnt == CW'(1)) begin
                        res_v   = sh_n;
                        carry_v = sh_bit;
                        fin     = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d    = DONE;
            result_d   = res_v;
            zero_d     = (res_v == '0);
            sign_d     = res_v[WIDTH-1];
            carry_d    = carry_v;
            overflow_d = ovf_v;
            illegal_d  = ill_v;
        end

        out_valid_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq: latency, result/flags, backpressure and reset abort.
module tb_alu_seq;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   fl;   // {illegal, zero, carry, sign, overflow}
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic [3:0]   control;
    logic         zero_flag, carry_flag, sign_flag, overflow_flag, illegal;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .control(control), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .sign_flag(sign_flag), .overflow_flag(overflow_flag), .illegal(illegal)
    );

    function automatic logic [4:0] flags_now();
        return {illegal, zero_flag, carry_flag, sign_flag, overflow_flag};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one op, check latency and outputs, optionally hold off out_ready, then hand off
    task automatic run_op(input string tag, input logic [3:0] ctl, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] er, input logic [4:0] ef,
                          input int elat, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        chk({tag, "/in_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1; a = av; b = bv; control = ctl;
        @(posedge clk);
        e.res = er; e.fl = ef; e.lat = elat;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom; control = 4'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "/latency"}, 64'(lat), 64'(e.lat));
        chk({tag, "/result"}, 64'(result), 64'(e.res));
        chk({tag, "/flags"}, 64'(flags_now()), 64'(e.fl));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; control = 4'($urandom);
            @(negedge clk);
            chk({tag, "/hold_valid"}, 64'({out_valid, in_ready}), 64'(2'b10));
            chk({tag, "/hold_result"}, 64'(result), 64'(e.res));
            chk({tag, "/hold_flags"}, 64'(flags_now()), 64'(e.fl));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/idle_after"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; control = '0;
        @(negedge clk);
        chk("reset/in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset/outputs", 64'({out_valid, result, flags_now()}), 64'(0));
        chk("reset/in_ready_rel", 64'(in_ready), 64'(1));

        run_op("add_ovf",  4'd0, 32'h7fffffff, 32'h7fffffff, 32'hfffffffe, 5'b00011, 1, 0);
        run_op("add_cry",  4'd0, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 5'b00110, 1, 0);
        run_op("sub_zero", 4'd1, 32'd5,        32'd5,        32'h00000000, 5'b01100, 1, 0);
        run_op("sub_brw",  4'd1, 32'd3,        32'd5,        32'hfffffffe, 5'b00010, 1, 0);
        run_op("sub_ovf",  4'd1, 32'h80000000, 32'd1,        32'h7fffffff, 5'b00101, 1, 0);
        run_op("xor_bp",   4'd4, 32'hffaaaa78, 32'h03a33f12, 32'hfc09956a, 5'b00010, 1, 10);
        run_op("and",      4'd2, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 5'b00010, 1, 0);
        run_op("or_zero",  4'd3, 32'd0,        32'd0,        32'd0,        5'b01000, 1, 0);
        run_op("sra4",     4'd7, 32'h80000000, 32'd4,        32'hf8000000, 5'b00010, 5, 0);
        run_op("sll0",     4'd5, 32'd1,        32'd0,        32'd1,        5'b00000, 1, 0);
        run_op("sll_cry",  4'd5, 32'h80000001, 32'd1,        32'd2,        5'b00100, 2, 0);
        run_op("srl_cry",  4'd6, 32'h0000000f, 32'd2,        32'd3,        5'b00100, 3, 0);
        run_op("srl_trunc",4'd6, 32'h00000100, 32'h00000025, 32'd8,        5'b00000, 6, 3);
        run_op("sra31",    4'd7, 32'h40000000, 32'd31,       32'd0,        5'b01100, 32, 0);
        run_op("illegal12",4'd12,32'h12345678, 32'h9abcdef0, 32'd0,        5'b11000, 1, 0);
`ifdef ALU_MUL_EN
        run_op("mul_big",  4'd8, 32'h00010000, 32'h00010000, 32'd0,        5'b01101, 33, 0);
        run_op("mul_3x5",  4'd8, 32'd3,        32'd5,        32'h0000000f, 5'b00000, 33, 2);
`else
        run_op("mul_ill",  4'd8, 32'd3,        32'd5,        32'd0,        5'b11000, 1, 0);
`endif

        // Abort a long iterative op with reset; no result may follow
        run_op("pre_abort", 4'd3, 32'h0000f000, 32'h0000000f, 32'h0000f00f, 5'b00000, 1, 0);
        @(negedge clk);
        in_valid = 1'b1; a = 32'd7; b = 32'd31;
`ifdef ALU_MUL_EN
        control = 4'd8;
`else
        control = 4'd5;
`endif
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort/busy", 64'({out_valid, in_ready}), 64'(2'b00));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort/in_ready_rst", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        chk("abort/outputs", 64'({out_valid, result, flags_now()}), 64'(0));
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("abort/no_out_valid", 64'(seen), 64'(0));
        chk("abort/idle", 64'(in_ready), 64'(1));

        run_op("post_abort", 4'd0, 32'd1, 32'd2, 32'd3, 5'b00000, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the KGP-RISC execute stage; successor to the 32-bit single-cycle ALU. Adds a valid/ready handshake on both sides, iterative shifts (one bit per cycle) and an optional iterative unsigned multiplier. Operands are latched on accept. Result and flags are held until the consumer takes them.

## Interface
- WIDTH, 32: operand/result width, ≥ 4, power of two
- SHW, $clog2(WIDTH): shift-amount width, taken from b[SHW-1:0]
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept (IDLE state only)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B / shift amount
- control  in  4  opcode
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  result
- zero_flag, carry_flag, sign_flag, overflow_flag  out  1 each  flags
- illegal  out  1  opcode not supported; qualified by out_valid

## Operation
- Opcodes: 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL. 9–15 are illegal.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY on in_valid && in_ready, for shift/MUL ops.
  - IDLE → DONE on in_valid && in_ready, for single-cycle and illegal ops.
  - BUSY → DONE when the counter expires.
  - DONE → IDLE on out_ready.
- in_ready = (state==IDLE) && !rst. in_valid is ignored in BUSY and DONE.
- ADD/SUB:
  - SUB is a + ~b + 1.
  - carry = carry-out of bit WIDTH−1, so SUB carry=1 means no borrow.
  - overflow = signed overflow.
- Logic ops: carry = 0, overflow = 0.
- Shifts:
  - Shift one position per BUSY cycle, shamt times.
  - carry = the last bit shifted out; 0 if shamt=0.
  - overflow = 0.
- MUL:
  - Unsigned shift-add over WIDTH cycles.
  - result = low WIDTH bits.
  - carry = overflow = (high WIDTH bits ≠ 0).
- All ops: zero = (result==0), sign = result[WIDTH−1].
- Illegal opcode: result 0, zero=1, other flags 0, illegal=1.
- result, flags and illegal are registered. They stay stable from out_valid rise until the handshake completes.

## Timing
- Reset, while rst is high and in the cycle after it: state IDLE, out_valid=0, result=0, all flags 0, illegal=0, counters cleared. in_ready=0 while rst is high.
- Accept in cycle N.
  - ADD/SUB/logic/illegal: out_valid at N+1.
  - Shift: out_valid at N+1+shamt.
  - MUL: out_valid at N+1+WIDTH.
- out_valid stays high until the cycle with out_ready=1. The block is in IDLE in the following cycle.
- Maximum throughput: one single-cycle op every 2 cycles.
- out_ready is ignored when out_valid=0.
- a/b/control may change freely after accept.
- rst mid-BUSY or mid-DONE aborts the operation. No out_valid is produced for it.
- SHW truncation: b bits above SHW−1 are ignored for shifts. Shifting by WIDTH is not expressible.

## Configuration
- ALU_MUL_EN defined: MUL datapath (accumulator, multiplicand, counter) is compiled in; opcode 8 behaves as above.
- ALU_MUL_EN undefined: opcode 8 is illegal, with 1-cycle latency and illegal=1; the multiplier logic is absent.

## Test plan
- ADD 7fffffff+7fffffff, accept at N, out_ready=1 -> out_valid at N+1: result fffffffe, sign=1, overflow=1, carry=0, zero=0; back to IDLE at N+2.
- ADD ffffffff+ffffffff -> fffffffe, carry=1, overflow=0. SUB 5−5 -> 0, zero=1, carry=1. XOR ffaaaa78^03a33f12 -> fc09956a, carry=overflow=0.
- SRA 80000000 by b=4 -> out_valid exactly 5 cycles after accept: result f8000000, carry=0, sign=1. SLL 1 by 0 -> 1 at N+1, carry=0.
- MUL 00010000*00010000 (ALU_MUL_EN) -> out_valid at N+33: result 0, zero=1, carry=overflow=1. MUL 3*5 -> f, carry=0. Without the macro, opcode 8 -> illegal=1, result 0 at N+1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid; toggle a/b/control/in_valid -> result and flags unchanged, in_ready=0. out_ready=1 -> IDLE next cycle.
- Assert rst during MUL BUSY -> next cycle IDLE, all outputs 0, no out_valid. Opcode 12 -> illegal=1, zero=1.
